spi_rx_multi_trig: RTL and testbench

Parametrised successor to the single-word SPI receive trigger. It is a passive SPI sniffer that deserialises MOSI into words of programmable length and counts the words in each frame. Each completed word is compared against NUM_MATCH independent mask/match channels. It raises a one-cycle trigger when any enabled channel hits on a selected word index of the frame. It sits in the protocol-trigger section alongside the other serial trigger receivers.

---
 rtl/spi_rx_multi_trig.sv | 183 ++++++++++++++++++
 tb/tb_spi_rx_multi_trig.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_rx_multi_trig.sv
// Passive SPI sniffer: deserialises MOSI into wlen-bit words and raises SPItrig when an enabled mask/match channel hits on word_sel.
// Define SPI_RX_TRIG_HOLD_EN to make SPItrig sticky until trig_clr; otherwise it is a one-cycle pulse.
module spi_rx_multi_trig #(
    parameter int DATA_W    = 16,
    parameter int NUM_MATCH = 4,
    parameter int CNT_W     = 4,
    localparam int WL_W     = $clog2(DATA_W + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        SS_n,
    input  logic                        SCLK,
    input  logic                        MOSI,
    input  logic                        edg,
    input  logic [WL_W-1:0]             wlen,
    input  logic [CNT_W-1:0]            word_sel,
    input  logic [NUM_MATCH-1:0]        match_en,
    input  logic [NUM_MATCH*DATA_W-1:0] mask,
    input  logic [NUM_MATCH*DATA_W-1:0] match,
    input  logic                        trig_clr,
    output logic [DATA_W-1:0]           rx_data,
    output logic                        rx_vld,
    output logic [NUM_MATCH-1:0]        hit,
    output logic [CNT_W-1:0]            word_cnt,
    output logic                        SPItrig,
    output logic                        frm_err
);

    typedef enum logic {IDLE = 1'b0, RX = 1'b1} state_t;

    function automatic logic [WL_W-1:0] eff_wlen(input logic [WL_W-1:0] w);
        if (w == '0 || int'(w) > DATA_W) return WL_W'(DATA_W);
        return w;
    endfunction

    function automatic logic [DATA_W-1:0] len_mask(input logic [WL_W-1:0] w);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int i = 0; i < DATA_W; i++) if (i < int'(w)) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    state_t                state_q, state_d;
    logic [2:0]            sclk_q, mosi_q;
    logic [1:0]            ssn_q;
    logic                  edg_q, edg_d;
    logic [WL_W-1:0]       wlen_q, wlen_d;
    logic [CNT_W-1:0]      wsel_q, wsel_d;
    logic [WL_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]      frm_cnt_q, frm_cnt_d;
    logic [DATA_W-1:0]     shift_q, shift_d;
    logic                  done_q, done_d;
    logic [DATA_W-1:0]     rx_data_q, rx_data_d;
    logic                  rx_vld_q, rx_vld_d;
    logic [NUM_MATCH-1:0]  hit_q, hit_d;
    logic [CNT_W-1:0]      word_cnt_q, word_cnt_d;
    logic                  trig_q, trig_d;
    logic                  frm_err_q, frm_err_d;
    logic                  sclk_rise, sclk_fall, ss_low;
    logic [DATA_W-1:0]     lenm, word;

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign ss_low    = ~ssn_q[1];
    assign lenm      = len_mask(wlen_q);
    assign word      = shift_q & lenm;

    always_comb begin
        state_d    = state_q;
        edg_d      = edg_q;
        wlen_d     = wlen_q;
        wsel_d     = wsel_q;
        bit_cnt_d  = bit_cnt_q;
        frm_cnt_d  = frm_cnt_q;
        shift_d    = shift_q;
        done_d     = 1'b0;
        rx_data_d  = rx_data_q;
        rx_vld_d   = 1'b0;
        hit_d      = hit_q;
        word_cnt_d = word_cnt_q;
        frm_err_d  = 1'b0;
`ifdef SPI_RX_TRIG_HOLD_EN
        trig_d     = trig_q & ~trig_clr;
`else
        trig_d     = 1'b0;
`endif

        // Framing stage: config is frozen while the frame is in progress
        case (state_q)
            IDLE: begin
                edg_d     = edg;
                wlen_d    = eff_wlen(wlen);
                wsel_d    = word_sel;
                bit_cnt_d = '0;
                frm_cnt_d = '0;
                if (ss_low) state_d = RX;
            end
            RX: begin
                if (!ss_low) begin
                    state_d   = IDLE;
                    frm_err_d = (bit_cnt_q != '0);
                end else if (edg_q ? sclk_rise : sclk_fall) begin
                    shift_d = {shift_q[DATA_W-2:0], mosi_q[2]};
                    if (bit_cnt_q + WL_W'(1) == wlen_q) begin
                        bit_cnt_d = '0;
                        done_d    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + WL_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Compare stage: one clk after the completing shift
        if (done_q) begin
            rx_data_d  = word;
            rx_vld_d   = 1'b1;
            word_cnt_d = frm_cnt_q;
            frm_cnt_d  = sat_inc(frm_cnt_q);
            for (int i = 0; i < NUM_MATCH; i++)
                hit_d[i] = match_en[i] &
                           ~|((word ^ match[i*DATA_W +: DATA_W]) & ~mask[i*DATA_W +: DATA_W] & lenm);
            if (|hit_d && frm_cnt_q == wsel_q) trig_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        if (rst) begin
            sclk_q     <= 3'b000;
            mosi_q     <= 3'b000;
            ssn_q      <= 2'b11;
            state_q    <= IDLE;
            edg_q      <= 1'b0;
            wlen_q     <= '0;
            wsel_q     <= '0;
            bit_cnt_q  <= '0;
            frm_cnt_q  <= '0;
            done_q     <= 1'b0;
            rx_data_q  <= '0;
            rx_vld_q   <= 1'b0;
            hit_q      <= '0;
            word_cnt_q <= '0;
            trig_q     <= 1'b0;
            frm_err_q  <= 1'b0;
        end else begin
            sclk_q     <= {sclk_q[1:0], SCLK};
            mosi_q     <= {mosi_q[1:0], MOSI};
            ssn_q      <= {ssn_q[0], SS_n};
            state_q    <= state_d;
            edg_q      <= edg_d;
            wlen_q     <= wlen_d;
            wsel_q     <= wsel_d;
            bit_cnt_q  <= bit_cnt_d;
            frm_cnt_q  <= frm_cnt_d;
            done_q     <= done_d;
            rx_data_q  <= rx_data_d;
            rx_vld_q   <= rx_vld_d;
            hit_q      <= hit_d;
            word_cnt_q <= word_cnt_d;
            trig_q     <= trig_d;
            frm_err_q  <= frm_err_d;
        end
    end

`ifndef SPI_RX_TRIG_HOLD_EN
    logic unused_trig_clr;
    assign unused_trig_clr = trig_clr;
`endif

    assign rx_data  = rx_data_q;
    assign rx_vld   = rx_vld_q;
    assign hit      = hit_q;
    assign word_cnt = word_cnt_q;
    assign SPItrig  = trig_q;
    assign frm_err  = frm_err_q;

endmodule

// File: tb/tb_spi_rx_multi_trig.sv
// Scoreboard bench for spi_rx_multi_trig: stimulus pushes expected words, a negedge monitor pops and compares on rx_vld.
module tb_spi_rx_multi_trig;
    localparam int DW  = 16;
    localparam int NM  = 4;
    localparam int CW  = 4;
    localparam int WLW = $clog2(DW + 1);
    localparam int H   = 4;

    logic              clk;
    logic              rst, SS_n, SCLK, MOSI, edg, trig_clr;
    logic [WLW-1:0]    wlen;
    logic [CW-1:0]     word_sel;
    logic [NM-1:0]     match_en;
    logic [NM*DW-1:0]  mask, match;
    logic [DW-1:0]     rx_data;
    logic              rx_vld, SPItrig, frm_err;
    logic [NM-1:0]     hit;
    logic [CW-1:0]     word_cnt;

    spi_rx_multi_trig #(.DATA_W(DW), .NUM_MATCH(NM), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .edg(edg),
        .wlen(wlen), .word_sel(word_sel), .match_en(match_en), .mask(mask), .match(match),
        .trig_clr(trig_clr), .rx_data(rx_data), .rx_vld(rx_vld), .hit(hit),
        .word_cnt(word_cnt), .SPItrig(SPItrig), .frm_err(frm_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic [NM-1:0] hit;
        logic [CW-1:0] wcnt;
        logic          trig;
        int            cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   chk_cnt = 0;
    int   pass_cnt = 0;
    int   frm_err_seen = 0;
    int   frm_err_exp = 0;
    logic sticky = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic exp_t mk(input logic [DW-1:0] d, input logic [NM-1:0] h,
                                input logic [CW-1:0] w, input logic cond);
        exp_t e;
        e.data = d;
        e.hit  = h;
        e.wcnt = w;
`ifdef SPI_RX_TRIG_HOLD_EN
        if (cond) sticky = 1'b1;
        e.trig = sticky;
`else
        e.trig = cond;
`endif
        e.cyc  = 0;
        return e;
    endfunction

    // Monitor: pops one expectation per rx_vld
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_vld) begin
                if (q.size() == 0) begin
                    chk_cnt++;
                    $display("FAIL unexpected_vld: got rx_data %0h, expected no word", rx_data);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("rx_data", rx_data, e.data);
                    chk("hit", hit, e.hit);
                    chk("word_cnt", word_cnt, e.wcnt);
                    chk("SPItrig", SPItrig, e.trig);
                    chk("latency", cyc, e.cyc);
                end
            end
`ifndef SPI_RX_TRIG_HOLD_EN
            if (SPItrig && !rx_vld) begin
                chk_cnt++;
                $display("FAIL trig_pulse: got SPItrig 1 without rx_vld, expected 0 (cycle %0d)", cyc);
            end
`endif
            if (frm_err) frm_err_seen++;
        end
    end

    task automatic push(input exp_t e);
        exp_t t;
        t = e;
        t.cyc = cyc + 4;
        q.push_back(t);
    endtask

    // fall_mode=0: MOSI set while SCLK low, then rise, then fall; fall_mode=1: MOSI changes with the rise
    task automatic drive_bit(input logic b, input logic fall_mode, input logic cfg_edg,
                             input logic last, input exp_t e);
        @(negedge clk);
        if (!fall_mode) begin
            MOSI = b;
            repeat (H) @(negedge clk);
            SCLK = 1'b1;
            if (last && cfg_edg) push(e);
            repeat (H) @(negedge clk);
            SCLK = 1'b0;
            if (last && !cfg_edg) push(e);
        end else begin
            SCLK = 1'b1;
            MOSI = b;
            if (last && cfg_edg) push(e);
            repeat (H) @(negedge clk);
            SCLK = 1'b0;
            if (last && !cfg_edg) push(e);
            repeat (H) @(negedge clk);
        end
    endtask

    task automatic send_word(input logic [DW-1:0] d, input int n, input logic fall_mode,
                             input logic cfg_edg, input logic do_push, input exp_t e);
        for (int k = n - 1; k >= 0; k--)
            drive_bit(d[k], fall_mode, cfg_edg, do_push && (k == 0), e);
    endtask

    task automatic start_frame;
        @(negedge clk);
        MOSI = 1'b0;
        SCLK = 1'b0;
        SS_n = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic end_frame;
        repeat (6) @(negedge clk);
        SS_n = 1'b1;
        repeat (8) @(negedge clk);
`ifdef SPI_RX_TRIG_HOLD_EN
        repeat (20) @(negedge clk);
        chk("trig_hold", SPItrig, sticky);
        trig_clr = 1'b1;
        @(negedge clk);
        chk("trig_clr", SPItrig, 0);
        trig_clr = 1'b0;
        sticky = 1'b0;
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by time limit, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t none;
        none = mk('0, '0, '0, 1'b0);
        rst = 1'b1; SS_n = 1'b1; SCLK = 1'b0; MOSI = 1'b0; edg = 1'b1; trig_clr = 1'b0;
        wlen = WLW'(16); word_sel = '0; match_en = '0; mask = '0; match = '0;
        repeat (4) @(negedge clk);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_vld", rx_vld, 0);
        chk("rst_hit", hit, 0);
        chk("rst_word_cnt", word_cnt, 0);
        chk("rst_SPItrig", SPItrig, 0);
        chk("rst_frm_err", frm_err, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // 16-bit word on rising edges, channel 0 exact match
        match_en = 4'b0001; match[0 +: DW] = 16'hA55A;
        start_frame;
        send_word(16'hA55A, 16, 1'b0, 1'b1, 1'b1, mk(16'hA55A, 4'b0001, 4'd0, 1'b1));
        end_frame;

        // Same word sampled on falling edges
        edg = 1'b0;
        start_frame;
        send_word(16'hA55A, 16, 1'b1, 1'b0, 1'b1, mk(16'hA55A, 4'b0001, 4'd0, 1'b1));
        end_frame;

        // Fall-timed data but rise sampling: each rise sees the previous bit
        edg = 1'b1;
        start_frame;
        send_word(16'hA55A, 16, 1'b1, 1'b1, 1'b1, mk(16'h52AD, 4'b0000, 4'd0, 1'b0));
        end_frame;

        // 8-bit word: bits above wlen are ignored; ch3 is a near miss
        wlen = WLW'(8);
        match_en = 4'b1010;
        match[1*DW +: DW] = 16'hFF3C;
        match[3*DW +: DW] = 16'h003D;
`ifndef SPI_RX_TRIG_HOLD_EN
        trig_clr = 1'b1;
`endif
        start_frame;
        send_word(16'h003C, 8, 1'b0, 1'b1, 1'b1, mk(16'h003C, 4'b0010, 4'd0, 1'b1));
        end_frame;
        trig_clr = 1'b0;

        // Multi-word frame, trigger only on word index 2; ch2 uses a don't-care nibble
        word_sel = 4'd2;
        match_en = 4'b0101;
        match[0 +: DW] = 16'h0033;
        match[2*DW +: DW] = 16'h0030;
        mask[2*DW +: DW] = 16'h000F;
        start_frame;
        send_word(16'h0011, 8, 1'b0, 1'b1, 1'b1, mk(16'h0011, 4'b0000, 4'd0, 1'b0));
        send_word(16'h0022, 8, 1'b0, 1'b1, 1'b1, mk(16'h0022, 4'b0000, 4'd1, 1'b0));
        send_word(16'h0033, 8, 1'b0, 1'b1, 1'b1, mk(16'h0033, 4'b0101, 4'd2, 1'b1));
        send_word(16'h0044, 8, 1'b0, 1'b1, 1'b1, mk(16'h0044, 4'b0000, 4'd3, 1'b0));
        end_frame;

        // 13-bit frame: one word then a partial word that must raise frm_err
        word_sel = 4'd0;
        match_en = 4'b0000;
        mask = '0;
        start_frame;
        send_word(16'h00A5, 8, 1'b0, 1'b1, 1'b1, mk(16'h00A5, 4'b0000, 4'd0, 1'b0));
        send_word(16'h0016, 5, 1'b0, 1'b1, 1'b0, none);
        frm_err_exp++;
        end_frame;

        // Reset mid-word with SS_n held low, then a fresh word in the same frame
        match_en = 4'b0001;
        match[0 +: DW] = 16'h005A;
        start_frame;
        send_word(16'h0013, 5, 1'b0, 1'b1, 1'b0, none);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_rx_data", rx_data, 0);
        chk("mid_rst_rx_vld", rx_vld, 0);
        chk("mid_rst_hit", hit, 0);
        chk("mid_rst_word_cnt", word_cnt, 0);
        chk("mid_rst_SPItrig", SPItrig, 0);
        chk("mid_rst_frm_err", frm_err, 0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        send_word(16'h005A, 8, 1'b0, 1'b1, 1'b1, mk(16'h005A, 4'b0001, 4'd0, 1'b1));
        end_frame;

        repeat (10) @(negedge clk);
        chk("frm_err_count", frm_err_seen, frm_err_exp);
        chk("queue_empty", q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
